// File: rtl/bsg_link_downstream_rx.sv
// bsg_link_downstream_rx
//   Downstream link receiver. Narrow IO beats are registered, assembled
//   little-endian into core words, buffered in a DEPTH-entry FIFO and
//   handed to the core over valid/ready. One credit token is returned
//   upstream per TOKEN_DECIM dequeued words.
// Ports
//   clk, rst          clock, synchronous active-high reset
//   io_valid_in/data  beat from the link (no backpressure)
//   core_ready        core accepts head word
//   core_valid_out    FIFO non-empty
//   core_data_out     head-of-FIFO word
//   io_token_out      one-cycle credit pulse to upstream
//   overflow_o        sticky: word arrived while full with no pop
//   count_o           FIFO occupancy
module bsg_link_downstream_rx #(
  parameter int IO_WIDTH    = 8,
  parameter int RATIO       = 4,
  parameter int DEPTH       = 8,
  parameter int TOKEN_DECIM = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         io_valid_in,
  input  logic [IO_WIDTH-1:0]          io_data_in,
  input  logic                         core_ready,
  output logic                         core_valid_out,
  output logic [IO_WIDTH*RATIO-1:0]    core_data_out,
  output logic                         io_token_out,
  output logic                         overflow_o,
  output logic [$clog2(DEPTH):0]       count_o
);
  localparam int CW = IO_WIDTH * RATIO;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int DW = (TOKEN_DECIM > 1) ? $clog2(TOKEN_DECIM) : 1;

  logic                          r_io_valid;
  logic [IO_WIDTH-1:0]           r_io_data;
  logic [BW-1:0]                 r_beat;
  logic [(RATIO-1)*IO_WIDTH-1:0] r_core_data0;
  logic [CW-1:0]                 r_mem [DEPTH];
  logic [PW-1:0]                 r_wptr, r_rptr;
  logic [DW-1:0]                 r_deq;
  logic                          r_token;
  logic                          r_ovf;

  logic w_last, w_empty, w_full, w_pop, w_push, w_deq_wrap;

  // Final beat of a word is sitting in the input register: offer it.
  assign w_last     = r_io_valid && (r_beat == BW'(RATIO-1));
  assign w_empty    = (r_wptr == r_rptr);
  assign w_full     = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign w_pop      = !w_empty && core_ready;
  // A pop in the same cycle frees the slot, so a push at full is still legal.
  assign w_push     = w_last && (!w_full || w_pop);
  assign w_deq_wrap = (TOKEN_DECIM == 1) || (r_deq == DW'(TOKEN_DECIM-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_io_valid <= 1'b0;
      r_io_data  <= '0;
    end else begin
      r_io_valid <= io_valid_in;
      r_io_data  <= io_data_in;
    end
  end

  // Beat assembler; the last beat bypasses core_data0 straight into the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat       <= '0;
      r_core_data0 <= '0;
    end else if (r_io_valid) begin
      if (w_last) begin
        r_beat <= '0;
      end else begin
        r_beat <= r_beat + BW'(1);
        for (int i = 0; i < RATIO-1; i++)
          if (r_beat == BW'(i)) r_core_data0[i*IO_WIDTH +: IO_WIDTH] <= r_io_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr[AW-1:0]] <= {r_io_data, r_core_data0};
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_deq   <= '0;
      r_token <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_pop) r_deq <= w_deq_wrap ? '0 : r_deq + DW'(1);
      r_token <= w_pop && w_deq_wrap;
      if (w_last && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  assign core_valid_out = !w_empty;
  assign core_data_out  = r_mem[r_rptr[AW-1:0]];
  assign io_token_out   = r_token;
  assign overflow_o     = r_ovf;
  assign count_o        = r_wptr - r_rptr;
endmodule

// File: tb/tb_bsg_link_downstream_rx.sv
// Testbench for bsg_link_downstream_rx: directed scenarios followed by
// randomized traffic. A queue-based model predicts occupancy, tokens and
// overflow; a monitor checks delivered words against a scoreboard queue.
module tb_bsg_link_downstream_rx;
  localparam int IOW = 8, RATIO = 4, DEPTH = 8, TD = 2;
  localparam int CW = IOW * RATIO;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            io_valid_in = 1'b0;
  logic [IOW-1:0]  io_data_in = '0;
  logic            core_ready = 1'b0;
  logic            core_valid_out;
  logic [CW-1:0]   core_data_out;
  logic            io_token_out;
  logic            overflow_o;
  logic [$clog2(DEPTH):0] count_o;

  bsg_link_downstream_rx #(.IO_WIDTH(IOW), .RATIO(RATIO), .DEPTH(DEPTH), .TOKEN_DECIM(TD)) dut (
    .clk(clk), .rst(rst), .io_valid_in(io_valid_in), .io_data_in(io_data_in),
    .core_ready(core_ready), .core_valid_out(core_valid_out), .core_data_out(core_data_out),
    .io_token_out(io_token_out), .overflow_o(overflow_o), .count_o(count_o));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard of words the model expects to be delivered, in order.
  logic [CW-1:0] sbq[$];

  // Model state: occupancy, dequeue count, pending token, sticky overflow,
  // beats collected so far and a word waiting one cycle to be offered.
  int          m_cnt = 0, m_deq = 0;
  bit          m_tok = 0, m_ovf = 0, m_offer = 0;
  logic [CW-1:0] m_word = '0;
  logic [IOW-1:0] m_beats[$];

  always @(negedge clk) begin
    chk("core_valid", core_valid_out, (m_cnt != 0));
    chk("count", count_o, m_cnt);
    chk("token", io_token_out, m_tok);
    chk("overflow", overflow_o, m_ovf);
    if (rst) begin
      m_cnt = 0; m_deq = 0; m_tok = 0; m_ovf = 0; m_offer = 0;
      m_beats.delete();
      sbq.delete();
    end else begin
      if (m_cnt != 0 && core_ready) begin
        m_cnt--;
        m_deq = (m_deq + 1) % TD;
        m_tok = (m_deq == 0);
      end else begin
        m_tok = 0;
      end
      if (m_offer) begin
        if (m_cnt < DEPTH) begin
          m_cnt++;
          sbq.push_back(m_word);
        end else begin
          m_ovf = 1;
        end
      end
      m_offer = 0;
      if (io_valid_in) begin
        m_beats.push_back(io_data_in);
        if (m_beats.size() == RATIO) begin
          for (int b = 0; b < RATIO; b++) m_word[b*IOW +: IOW] = m_beats[b];
          m_offer = 1;
          m_beats.delete();
        end
      end
    end
  end

  // Monitor: whenever a word is presented it must match the scoreboard head;
  // it is retired on handshake.
  always @(negedge clk) begin
    if (!rst && core_valid_out) begin
      if (sbq.size() == 0) begin
        n_chk++;
        $display("FAIL core_data_unexpected: got %0h expected no word at %0t", core_data_out, $time);
      end else begin
        chk("core_data", core_data_out, sbq[0]);
        if (core_ready) void'(sbq.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    io_valid_in = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic beat(input logic [IOW-1:0] d);
    io_valid_in = 1'b1;
    io_data_in  = d;
    cyc();
    io_valid_in = 1'b0;
  endtask

  task automatic word(input logic [CW-1:0] w, input int maxgap, input int mingap);
    for (int b = 0; b < RATIO; b++) begin
      beat(w[b*IOW +: IOW]);
      if (maxgap > 0 && b < RATIO-1) idle($urandom_range(maxgap, mingap));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    logic [CW-1:0] w;
    idle(3);
    rst = 1'b0;
    chk("rst_data_out", core_data_out, 0);

    // Single word, then a second one that completes a token group.
    core_ready = 1'b1;
    word(32'h44332211, 0, 0);
    idle(4);
    word(32'h88776655, 0, 0);
    idle(6);

    // Gapped beats.
    word(32'hEFBEADDE, 3, 1);
    idle(6);

    // Fill, overflow, drain.
    core_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      w = {4{8'(i)}};
      word(w, 0, 0);
    end
    idle(4);
    chk("fill_overflow", overflow_o, 1);
    core_ready = 1'b1;
    idle(14);

    // Push and pop at full.
    do_reset();
    core_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w = {4{8'(8'h10 + i)}};
      word(w, 0, 0);
    end
    idle(3);
    word(32'hCAFEF00D, 0, 0);
    core_ready = 1'b1;   // pop in the cycle the new word is offered
    cyc();
    core_ready = 1'b0;
    idle(2);
    chk("full_pushpop_count", count_o, DEPTH);
    core_ready = 1'b1;
    idle(14);

    // Backpressure with 3 queued words.
    core_ready = 1'b0;
    word(32'h0A0B0C0D, 0, 0);
    word(32'h1A1B1C1D, 0, 0);
    word(32'h2A2B2C2D, 0, 0);
    idle(3);
    core_ready = 1'b1; cyc();
    core_ready = 1'b0; cyc(); cyc();
    core_ready = 1'b1; idle(6);

    // Reset mid-word.
    beat(8'h01);
    beat(8'h02);
    rst = 1'b1; cyc(); rst = 1'b0;
    word(32'hA3A2A1A0, 0, 0);
    idle(6);

    // Randomized traffic with rare resets.
    for (int c = 0; c < 3000; c++) begin
      io_valid_in = ($urandom_range(3, 0) != 0);
      io_data_in  = 8'($urandom);
      core_ready  = ($urandom_range(2, 0) != 0);
      rst         = ($urandom_range(499, 0) == 0);
      cyc();
    end
    rst = 1'b0;
    core_ready = 1'b1;
    idle(20);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
